arb_mux_n: RTL

Parametrised N-input, registered, handshaked multiplexer. It is the successor to the combinational 4-way datapath select. It merges N valid/ready producers onto one registered output in one of two modes: explicit select, or round-robin arbitration. It sits wherever several pipeline sources share one consumer, for example writeback-source merging or memory-request merging. It provides one cycle of registered latency and full one-word-per-cycle throughput.

---
 rtl/arb_mux_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/arb_mux_n.sv | 61 ++++++
 3 files changed

// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared mode encodings and width helper for the arb_mux_n family
package arb_mux_pkg;
    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int selw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant, searching upward from ptr+1 with wrap
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = selw(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt
);
    logic [N-1:0]   mask;
    logic [2*N-1:0] d;
    logic [2*N-1:0] iso;

    // low half holds requests above ptr, high half all requests; lowest set bit wins
    always_comb begin
        mask = {N{1'b1}} << (int'(ptr) + 1);
        d    = {req, req & mask};
        iso  = d & -d;
        gnt  = iso[N-1:0] | iso[2*N-1:N];
    end
endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: N-input registered valid/ready mux, explicit select or round-robin
module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = MODE_SEL,
    parameter int SELW  = selw(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_id
);
    logic [N-1:0]    gnt;
    logic [SELW-1:0] idx;
    logic            free;
    logic            any;

    // rst_n gates free so in_ready drops the moment reset is asserted
    always_comb begin
        free = rst_n & (!out_valid | out_ready);
        any  = |gnt;
        idx  = '0;
        for (int i = 0; i < N; i++) if (gnt[i]) idx = SELW'(i);
        in_ready = gnt & {N{free}};
    end

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] ptr;
            logic            unused_sel;
            assign unused_sel = ^sel;
            rr_arbiter #(.N(N), .SELW(SELW)) u_arb (.req(in_valid), .ptr(ptr), .gnt(gnt));
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) ptr <= SELW'(N - 1);
                else if (any && free) ptr <= idx;
        end else begin : g_sel
            always_comb for (int i = 0; i < N; i++) gnt[i] = in_valid[i] && (int'(sel) == i);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (free) begin
            out_valid <= any;
            if (any) begin
                out_data <= in_data[idx*WIDTH +: WIDTH];
                out_id   <= idx;
            end
        end
endmodule
